register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameters: REG_NUM, default 32, architectural register count; ROB_W, default 6, ROB index width; XLEN, default 32, data width.
REQ-002 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port rdy, input, 1, global enable; low freezes all state.
REQ-005 The block SHALL have ports issue_valid (input, 1), issue_rd (input, 5) and issue_index (input, ROB_W), meaning rename of rd to a ROB tag.
REQ-006 The block SHALL have ports query_rs1 and query_rs2 (input, 5 each), meaning operand register numbers from the issue unit.
REQ-007 The block SHALL have ports rs1_busy, rs2_busy (output, 1), rs1_tag, rs2_tag (output, ROB_W) and rs1_value, rs2_value (output, XLEN), meaning operand status, tag and value.
REQ-008 The block SHALL have ports rf_valid (input, 1), rf_index (input, ROB_W), rf_rd (input, 5) and rf_value (input, XLEN), meaning the commit write from the reorder buffer.
REQ-009 The block SHALL have port flush, input, 1, meaning mispredict recovery.

Function
REQ-010 State SHALL be per register: value[XLEN], busy bit and tag[ROB_W].
REQ-011 Register x0 SHALL always read value 0 and busy 0, and SHALL never be written or tagged.
REQ-012 On commit (rf_valid and rf_rd != 0), value[rf_rd] SHALL be written with rf_value at the next edge.
REQ-013 On commit, busy[rf_rd] SHALL be cleared only if tag[rf_rd] == rf_index and no same-cycle issue targets rf_rd.
REQ-014 On issue (issue_valid and issue_rd != 0 and not flush), busy[issue_rd] SHALL be set to 1 and tag[issue_rd] set to issue_index, overriding a same-cycle commit clear.
REQ-015 On flush, all busy bits SHALL clear at the next edge.
REQ-016 Flush SHALL take priority over issue in the same cycle; the issue rename is dropped.
REQ-017 A commit in the flush cycle SHALL still write its value.
REQ-018 Read ports SHALL be combinational, with zero latency.
REQ-019 Read ports SHALL return pre-edge state, so an instruction reading its own rd sees the prior tag.
REQ-020 Commit bypass: if rf_valid and rf_rd == query_rsN != 0, rsN_value SHALL be rf_value.
REQ-021 Under the same commit-bypass condition, rsN_busy SHALL be 0 when tag[rf_rd] == rf_index; otherwise the stored busy/tag are returned.
REQ-022 When busy is 0, rsN_tag SHALL be don't-care but driven to 0.
REQ-023 When rdy is low, no state SHALL change; reads still reflect current state.

Reset
REQ-024 While rst is high, all value entries SHALL be 0, all busy bits 0 and all tags 0, immediately and independent of clk and rdy.
REQ-025 Reset asserted mid-operation SHALL discard pending issue/commit of that cycle.
REQ-026 The first edge after rst deasserts SHALL accept issue and commit normally.

Structure
REQ-027 REG_NUM, ROB_W, XLEN and the register number ZERO SHALL be defined in the shared config package alongside the existing opcode defines.
REQ-028 One sub-module, regfile_read_port, SHALL implement lookup plus commit bypass and be instantiated twice (rs1, rs2).
REQ-029 No other hierarchy SHALL exist.

Verification
REQ-030 Reset then query x5 -> busy 0, value 0; issue rd=5 idx=3, next cycle query x5 -> busy 1, tag 3.
REQ-031 x5 tagged 3; commit rf_rd=5 idx=3 value 0xDEADBEEF with query x5 same cycle -> busy 0, value 0xDEADBEEF; next cycle stored busy 0.
REQ-032 x5 tagged 3, issue rd=5 idx=7; commit idx=3 value 0x11 -> value[5]=0x11, busy 1, tag 7 retained.
REQ-033 Same-cycle issue rd=8 idx=9 and commit rf_rd=8 idx=2 (x8 tagged 2) -> busy[8]=1, tag 9, value[8]=commit value.
REQ-034 x1..x4 busy, flush with issue rd=1 idx=5 and commit rd=2 value 0x42 -> all busy 0, value[2]=0x42, x1 untagged.
REQ-035 Issue/commit targeting x0 with value 0xFF, and rdy low with issue rd=6 -> x0 reads 0/not busy; x6 unchanged.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared core config: architectural sizes, zero register and opcodes.
// Imported by the register file, its interface and its read ports.
package register_file_pkg;
  localparam int REG_NUM = 32;
  localparam int ROB_W   = 6;
  localparam int XLEN    = 32;

  localparam logic [4:0] ZERO = 5'd0;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic is_zero(input logic [4:0] r);
    return r == ZERO;
  endfunction
endpackage

// File: rtl/register_file_if.sv
// Register file bus: rename/issue, operand query, commit, flush, rdy.
// master = issue unit + ROB side, slave = register file.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int ROB_W = register_file_pkg::ROB_W,
  parameter int XLEN  = register_file_pkg::XLEN
);
  logic             rdy;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [ROB_W-1:0] issue_index;
  logic [4:0]       query_rs1;
  logic [4:0]       query_rs2;
  logic             rs1_busy;
  logic             rs2_busy;
  logic [ROB_W-1:0] rs1_tag;
  logic [ROB_W-1:0] rs2_tag;
  logic [XLEN-1:0]  rs1_value;
  logic [XLEN-1:0]  rs2_value;
  logic             rf_valid;
  logic [ROB_W-1:0] rf_index;
  logic [4:0]       rf_rd;
  logic [XLEN-1:0]  rf_value;
  logic             flush;

  modport master (
    output rdy, issue_valid, issue_rd, issue_index,
    output query_rs1, query_rs2,
    output rf_valid, rf_index, rf_rd, rf_value, flush,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag,
    input  rs1_value, rs2_value
  );

  modport slave (
    input  rdy, issue_valid, issue_rd, issue_index,
    input  query_rs1, query_rs2,
    input  rf_valid, rf_index, rf_rd, rf_value, flush,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag,
    output rs1_value, rs2_value
  );
endinterface

// File: rtl/register_file_read_port.sv
// One operand read port: table lookup plus same-cycle commit bypass.
// In: query, stored busy/tag/value, commit bus. Out: busy, tag, value.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int REG_NUM = register_file_pkg::REG_NUM,
  parameter int ROB_W   = register_file_pkg::ROB_W,
  parameter int XLEN    = register_file_pkg::XLEN
) (
  input  logic [4:0]                     query,
  input  logic [REG_NUM-1:0]             busy_q,
  input  logic [REG_NUM-1:0][ROB_W-1:0]  tag_q,
  input  logic [REG_NUM-1:0][XLEN-1:0]   value_q,
  input  logic                           rf_valid,
  input  logic [4:0]                     rf_rd,
  input  logic [ROB_W-1:0]               rf_index,
  input  logic [XLEN-1:0]                rf_value,
  output logic                           busy,
  output logic [ROB_W-1:0]               tag,
  output logic [XLEN-1:0]                value
);
  logic byp;
  logic hit;

  assign byp = rf_valid && (rf_rd == query);
  // Commit retires the producer we were waiting on.
  assign hit = byp && (tag_q[query] == rf_index);

  always_comb begin
    busy  = 1'b0;
    tag   = '0;
    value = '0;
    if (!is_zero(query)) begin
      value = byp ? rf_value : value_q[query];
      busy  = busy_q[query] && !hit;
      tag   = busy ? tag_q[query] : '0;
    end
  end
endmodule

// File: rtl/register_file.sv
// Renaming register file: value, busy and ROB tag per register.
// Ports: clk, rst (async high), bus (slave modport of register_file_if).
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_NUM = register_file_pkg::REG_NUM,
  parameter int ROB_W   = register_file_pkg::ROB_W,
  parameter int XLEN    = register_file_pkg::XLEN
) (
  input  logic               clk,
  input  logic               rst,
  register_file_if.slave     bus
);
  logic [REG_NUM-1:0]            busy_q;
  logic [REG_NUM-1:0][ROB_W-1:0] tag_q;
  logic [REG_NUM-1:0][XLEN-1:0]  value_q;

  logic issue_ok;
  logic commit_ok;
  logic commit_clr;

  assign issue_ok  = bus.issue_valid && !is_zero(bus.issue_rd)
                   && !bus.flush;
  assign commit_ok = bus.rf_valid && !is_zero(bus.rf_rd);
  // A same-cycle rename of rf_rd wins over the retiring producer.
  assign commit_clr = commit_ok
                    && (tag_q[bus.rf_rd] == bus.rf_index)
                    && !(issue_ok && bus.issue_rd == bus.rf_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      tag_q   <= '0;
      value_q <= '0;
    end else if (bus.rdy) begin
      if (commit_ok)
        value_q[bus.rf_rd] <= bus.rf_value;
      if (bus.flush) begin
        busy_q <= '0;
      end else begin
        if (commit_clr)
          busy_q[bus.rf_rd] <= 1'b0;
        if (issue_ok) begin
          busy_q[bus.issue_rd] <= 1'b1;
          tag_q[bus.issue_rd]  <= bus.issue_index;
        end
      end
    end
  end

  regfile_read_port #(
    .REG_NUM(REG_NUM), .ROB_W(ROB_W), .XLEN(XLEN)
  ) u_rs1 (
    .query    (bus.query_rs1),
    .busy_q   (busy_q),
    .tag_q    (tag_q),
    .value_q  (value_q),
    .rf_valid (bus.rf_valid),
    .rf_rd    (bus.rf_rd),
    .rf_index (bus.rf_index),
    .rf_value (bus.rf_value),
    .busy     (bus.rs1_busy),
    .tag      (bus.rs1_tag),
    .value    (bus.rs1_value)
  );

  regfile_read_port #(
    .REG_NUM(REG_NUM), .ROB_W(ROB_W), .XLEN(XLEN)
  ) u_rs2 (
    .query    (bus.query_rs2),
    .busy_q   (busy_q),
    .tag_q    (tag_q),
    .value_q  (value_q),
    .rf_valid (bus.rf_valid),
    .rf_rd    (bus.rf_rd),
    .rf_index (bus.rf_index),
    .rf_value (bus.rf_value),
    .busy     (bus.rs2_busy),
    .tag      (bus.rs2_tag),
    .value    (bus.rs2_value)
  );
endmodule
